// File: rtl/sysarr_os_mm.sv
// Output-stationary NxN systolic multiplier C = A*B with internal operand skew and row-serial drain.
// Row 0 is presented 2N cycles after the N-th operand beat; in_ready drops after N beats; the drain ignores backpressure.
module sysarr_os_mm #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N*DW-1:0]               a_col,
    input  logic [N*DW-1:0]               b_row,
    output logic                          out_valid,
    output logic [N*(2*DW+$clog2(N))-1:0] c_row,
    output logic                          busy
);

    localparam int ACCW = 2*DW + $clog2(N);
    localparam int CW   = $clog2(2*N);
    localparam int RW   = $clog2(N);
    localparam int SKN  = N*(N-1)/2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N*ACCW-1:0] c_row_q, c_row_d;
    logic [RW-1:0]     row_sel;
    logic              load_row, drain_done, dp_clr, accept;
    logic [N*DW-1:0]   a_inj, b_inj;

    // Triangular skew storage: row/column i owns i stages starting at sk_base(i).
    logic [DW-1:0]   ask_q [SKN];
    logic            askv_q[SKN];
    logic [DW-1:0]   bsk_q [SKN];
    logic            bskv_q[SKN];
    logic [DW-1:0]   ah_q  [N][N-1];
    logic            ahv_q [N][N-1];
    logic [DW-1:0]   bv_q  [N-1][N];
    logic            bvv_q [N-1][N];
    logic [ACCW-1:0] acc_q [N][N];
    logic [DW-1:0]   pa    [N][N];
    logic            pav   [N][N];
    logic [DW-1:0]   pb    [N][N];
    logic            pbv   [N][N];

    function automatic int sk_base(input int i);
        return i*(i-1)/2;
    endfunction

    function automatic logic [ACCW-1:0] mul_ext(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] xe, ye, p;
        xe = {{DW{(SIGNED != 0) && x[DW-1]}}, x};
        ye = {{DW{(SIGNED != 0) && y[DW-1]}}, y};
        p  = xe * ye;
        return {{(ACCW-2*DW){(SIGNED != 0) && p[2*DW-1]}}, p};
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DRAIN);
    assign c_row     = c_row_q;
    assign accept    = in_valid && in_ready && !clr;
    assign a_inj     = accept ? a_col : '0;
    assign b_inj     = accept ? b_row : '0;
    assign dp_clr    = clr || drain_done;

    always_comb begin
        pa[0][0]  = a_inj[DW-1:0];
        pav[0][0] = accept;
        pb[0][0]  = b_inj[DW-1:0];
        pbv[0][0] = accept;
        for (int i = 1; i < N; i++) begin
            pa[i][0]  = ask_q[sk_base(i)+i-1];
            pav[i][0] = askv_q[sk_base(i)+i-1];
            pb[0][i]  = bsk_q[sk_base(i)+i-1];
            pbv[0][i] = bskv_q[sk_base(i)+i-1];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                pa[i][j]  = ah_q[i][j-1];
                pav[i][j] = ahv_q[i][j-1];
                pb[j][i]  = bv_q[j-1][i];
                pbv[j][i] = bvv_q[j-1][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SKN; s++) begin
                ask_q[s] <= '0; askv_q[s] <= 1'b0; bsk_q[s] <= '0; bskv_q[s] <= 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
                for (int j = 0; j < N-1; j++) begin
                    ah_q[i][j] <= '0; ahv_q[i][j] <= 1'b0; bv_q[j][i] <= '0; bvv_q[j][i] <= 1'b0;
                end
            end
        end else if (dp_clr) begin
            for (int s = 0; s < SKN; s++) begin
                ask_q[s] <= '0; askv_q[s] <= 1'b0; bsk_q[s] <= '0; bskv_q[s] <= 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) acc_q[i][j] <= '0;
                for (int j = 0; j < N-1; j++) begin
                    ah_q[i][j] <= '0; ahv_q[i][j] <= 1'b0; bv_q[j][i] <= '0; bvv_q[j][i] <= 1'b0;
                end
            end
        end else begin
            for (int i = 1; i < N; i++) begin
                ask_q[sk_base(i)]  <= a_inj[i*DW +: DW];
                askv_q[sk_base(i)] <= accept;
                bsk_q[sk_base(i)]  <= b_inj[i*DW +: DW];
                bskv_q[sk_base(i)] <= accept;
                for (int d = 1; d < i; d++) begin
                    ask_q[sk_base(i)+d]  <= ask_q[sk_base(i)+d-1];
                    askv_q[sk_base(i)+d] <= askv_q[sk_base(i)+d-1];
                    bsk_q[sk_base(i)+d]  <= bsk_q[sk_base(i)+d-1];
                    bskv_q[sk_base(i)+d] <= bskv_q[sk_base(i)+d-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N-1; j++) begin
                    ah_q[i][j]  <= pa[i][j];
                    ahv_q[i][j] <= pav[i][j];
                    bv_q[j][i]  <= pb[j][i];
                    bvv_q[j][i] <= pbv[j][i];
                end
                for (int j = 0; j < N; j++) begin
                    if (pav[i][j] && pbv[i][j])
                        acc_q[i][j] <= acc_q[i][j] + mul_ext(pa[i][j], pb[i][j]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_row_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_row_q <= c_row_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        c_row_d    = c_row_q;
        load_row   = 1'b0;
        drain_done = 1'b0;
        row_sel    = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    cnt_d   = CW'(1);
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == CW'(N-1)) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FLUSH: begin
                // Last flush cycle: every accumulator is final, so stage row 0 now.
                if (cnt_q == CW'(2*N-2)) begin
                    state_d  = DRAIN;
                    cnt_d    = '0;
                    load_row = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (cnt_q == CW'(N-1)) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    drain_done = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    load_row = 1'b1;
                    row_sel  = RW'(cnt_q) + RW'(1);
                end
            end
        endcase
        if (load_row) begin
            for (int j = 0; j < N; j++) c_row_d[j*ACCW +: ACCW] = acc_q[row_sel][j];
        end
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            c_row_d = '0;
        end
    end

endmodule

// File: tb/tb_sysarr_os_mm.sv
// Scoreboard bench: N=3 unsigned and signed arrays share stimulus, plus an N=4 signed array for back-to-back jobs.
module tb_sysarr_os_mm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_n, clr3, v3, clr4, v4;
    logic [23:0] a3, b3;
    logic [15:0] a4, b4;
    wire         rdy3, rdy3s, rdy4, ov3, ov3s, ov4, busy3, busy3s, busy4;
    wire  [53:0] c3, c3s;
    wire  [39:0] c4;

    sysarr_os_mm #(.N(3), .DW(8), .SIGNED(0)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr3), .in_valid(v3), .in_ready(rdy3),
        .a_col(a3), .b_row(b3), .out_valid(ov3), .c_row(c3), .busy(busy3));
    sysarr_os_mm #(.N(3), .DW(8), .SIGNED(1)) u3s (
        .clk(clk), .rst_n(rst_n), .clr(clr3), .in_valid(v3), .in_ready(rdy3s),
        .a_col(a3), .b_row(b3), .out_valid(ov3s), .c_row(c3s), .busy(busy3s));
    sysarr_os_mm #(.N(4), .DW(4), .SIGNED(1)) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .in_valid(v4), .in_ready(rdy4),
        .a_col(a4), .b_row(b4), .out_valid(ov4), .c_row(c4), .busy(busy4));

    int ma[3][3], mb[3][3];
    int ja[2][4][4], jb[2][4][4];
    logic [53:0] exp3_q[$], exp3s_q[$];
    logic [39:0] exp4_q[$];

    function automatic int sx(input int raw, input int bits, input bit sgn);
        return (sgn && raw >= (1 << (bits-1))) ? raw - (1 << bits) : raw;
    endfunction

    function automatic logic [53:0] gold3(input int r, input bit sgn);
        logic [53:0] row;
        int s;
        row = '0;
        for (int j = 0; j < 3; j++) begin
            s = 0;
            for (int k = 0; k < 3; k++) s += sx(ma[r][k], 8, sgn) * sx(mb[k][j], 8, sgn);
            row[j*18 +: 18] = s[17:0];
        end
        return row;
    endfunction

    function automatic logic [39:0] gold4(input int job, input int r);
        logic [39:0] row;
        int s;
        row = '0;
        for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int k = 0; k < 4; k++) s += sx(ja[job][r][k], 4, 1'b1) * sx(jb[job][k][j], 4, 1'b1);
            row[j*10 +: 10] = s[9:0];
        end
        return row;
    endfunction

    task automatic fill3(input int kind);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                case (kind)
                    0: begin ma[i][j] = (i == j) ? 1 : 0; mb[i][j] = i*3 + j + 1; end
                    1: begin ma[i][j] = 255; mb[i][j] = 255; end
                    2: begin ma[i][j] = 128; mb[i][j] = 128; end
                    3: begin ma[i][j] = 1; mb[i][j] = 1; end
                    default: begin ma[i][j] = $urandom_range(0, 255); mb[i][j] = $urandom_range(0, 255); end
                endcase
            end
    endtask

    task automatic drive3(input int gap, output int l_cyc);
        exp3_q.delete();
        exp3s_q.delete();
        for (int r = 0; r < 3; r++) begin
            exp3_q.push_back(gold3(r, 1'b0));
            exp3s_q.push_back(gold3(r, 1'b1));
        end
        l_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) repeat (gap) begin @(negedge clk); v3 = 1'b0; end
            @(negedge clk);
            v3 = 1'b1;
            for (int i = 0; i < 3; i++) begin
                a3[i*8 +: 8] = 8'(ma[i][k]);
                b3[i*8 +: 8] = 8'(mb[k][i]);
            end
            n_tests++;
            if (rdy3 !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_load beat%0d: got %b want 1", k, rdy3);
            end
            if (k == 2) l_cyc = cyc;
        end
        @(negedge clk);
        v3 = 1'b0;
    endtask

    task automatic drain3(input int l_cyc, input string tag);
        int w;
        logic [53:0] e, es;
        for (int r = 0; r < 3; r++) begin
            w = 0;
            @(negedge clk);
            while (!ov3 && w < 40) begin @(negedge clk); w++; end
            n_tests++;
            if (!ov3) begin
                n_fail++;
                $display("FAIL %s row%0d timeout: out_valid %b want 1", tag, r, ov3);
                break;
            end
            n_tests++;
            if (cyc != l_cyc + 6 + r) begin
                n_fail++;
                $display("FAIL %s row%0d cycle: got %0d want %0d", tag, r, cyc - l_cyc, 6 + r);
            end
            e  = (exp3_q.size() > 0) ? exp3_q.pop_front() : 'x;
            es = (exp3s_q.size() > 0) ? exp3s_q.pop_front() : 'x;
            n_tests++;
            if (c3 !== e) begin
                n_fail++;
                $display("FAIL %s row%0d unsigned c_row: got %h want %h", tag, r, c3, e);
            end
            n_tests++;
            if (ov3s !== 1'b1 || c3s !== es) begin
                n_fail++;
                $display("FAIL %s row%0d signed c_row: got %b/%h want 1/%h", tag, r, ov3s, c3s, es);
            end
            n_tests++;
            if (rdy3 !== 1'b0 || busy3 !== 1'b1) begin
                n_fail++;
                $display("FAIL %s row%0d drain flags: rdy %b busy %b want 0 1", tag, r, rdy3, busy3);
            end
        end
        @(negedge clk);
        n_tests++;
        if (ov3 !== 1'b0 || busy3 !== 1'b0 || rdy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s after drain: ov %b busy %b rdy %b want 0 0 1", tag, ov3, busy3, rdy3);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (rdy3 !== 1'b1 || ov3 !== 1'b0 || busy3 !== 1'b0 || c3 !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_n3: rdy %b ov %b busy %b c %h want 1 0 0 0", rdy3, ov3, busy3, c3);
        end
        n_tests++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0 || c4 !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_n4: rdy %b ov %b busy %b c %h want 1 0 0 0", rdy4, ov4, busy4, c4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (rdy3s !== 1'b1 || ov3s !== 1'b0 || busy3s !== 1'b0 || c3s !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_idle: rdy %b ov %b busy %b c %h want 1 0 0 0", rdy3s, ov3s, busy3s, c3s);
        end
    endtask

    task automatic test_identity;
        int l_cyc;
        fill3(0);
        drive3(0, l_cyc);
        drain3(l_cyc, "identity");
    endtask

    task automatic test_extremes;
        int l_cyc;
        fill3(1);
        drive3(0, l_cyc);
        drain3(l_cyc, "all255");
        fill3(2);
        drive3(0, l_cyc);
        drain3(l_cyc, "all128");
    endtask

    task automatic test_bubbles;
        int l_cyc;
        fill3(0);
        drive3(2, l_cyc);
        drain3(l_cyc, "bubbles");
    endtask

    task automatic test_clr;
        int l_cyc;
        bit seen;
        fill3(4);
        drive3(0, l_cyc);
        @(negedge clk);
        clr3 = 1'b1;
        v3   = 1'b1;
        @(negedge clk);
        clr3 = 1'b0;
        v3   = 1'b0;
        n_tests++;
        if (busy3 !== 1'b0 || rdy3 !== 1'b1 || ov3 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_flush: busy %b rdy %b ov %b want 0 1 0", busy3, rdy3, ov3);
        end
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (ov3 || ov3s) seen = 1'b1; end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL clr_no_output: out_valid seen %b want 0", seen);
        end
        v3   = 1'b1;
        clr3 = 1'b1;
        @(negedge clk);
        v3   = 1'b0;
        clr3 = 1'b0;
        n_tests++;
        if (busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_beats_accept: busy %b want 0", busy3);
        end
        fill3(3);
        drive3(0, l_cyc);
        drain3(l_cyc, "after_clr");
    endtask

    task automatic test_reset_mid_drain;
        int l_cyc, w;
        fill3(0);
        drive3(0, l_cyc);
        w = 0;
        while (!ov3 && w < 40) begin @(negedge clk); w++; end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ov3 !== 1'b0 || busy3 !== 1'b0 || c3 !== 54'd0 || c3s !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: ov %b busy %b c %h cs %h want 0 0 0 0", ov3, busy3, c3, c3s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill3(4);
        drive3(0, l_cyc);
        drain3(l_cyc, "after_reset");
    endtask

    task automatic test_back_to_back;
        int first_acc[2], last_acc[2], rowcyc[8], w;
        bit stalled;
        logic [39:0] e;
        exp4_q.delete();
        for (int job = 0; job < 2; job++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ja[job][i][j] = $urandom_range(0, 15);
                    jb[job][i][j] = $urandom_range(0, 15);
                end
            for (int r = 0; r < 4; r++) exp4_q.push_back(gold4(job, r));
        end
        for (int r = 0; r < 8; r++) rowcyc[r] = -1;
        stalled = 1'b0;
        fork
            begin
                for (int job = 0; job < 2; job++)
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        v4 = 1'b1;
                        for (int i = 0; i < 4; i++) begin
                            a4[i*4 +: 4] = 4'(ja[job][i][k]);
                            b4[i*4 +: 4] = 4'(jb[job][k][i]);
                        end
                        w = 0;
                        while (!rdy4 && w < 40) begin @(negedge clk); w++; end
                        if (!rdy4) stalled = 1'b1;
                        if (k == 0) first_acc[job] = cyc;
                        if (k == 3) last_acc[job] = cyc;
                    end
                @(negedge clk);
                v4 = 1'b0;
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    int t;
                    t = 0;
                    @(negedge clk);
                    while (!ov4 && t < 80) begin @(negedge clk); t++; end
                    n_tests++;
                    if (!ov4) begin
                        n_fail++;
                        $display("FAIL b2b row%0d timeout: out_valid %b want 1", r, ov4);
                        break;
                    end
                    rowcyc[r] = cyc;
                    e = (exp4_q.size() > 0) ? exp4_q.pop_front() : 'x;
                    n_tests++;
                    if (c4 !== e) begin
                        n_fail++;
                        $display("FAIL b2b job%0d row%0d c_row: got %h want %h", r / 4, r % 4, c4, e);
                    end
                end
            end
        join
        n_tests++;
        if (stalled || first_acc[1] != last_acc[0] + 12) begin
            n_fail++;
            $display("FAIL b2b second_accept: got L1+%0d (stall %b) want L1+12", first_acc[1] - last_acc[0], stalled);
        end
        for (int r = 0; r < 8; r++) begin
            n_tests++;
            if (rowcyc[r] != last_acc[r/4] + 8 + r % 4) begin
                n_fail++;
                $display("FAIL b2b row%0d cycle: got L+%0d want L+%0d", r, rowcyc[r] - last_acc[r/4], 8 + r % 4);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr3  = 1'b0;
        clr4  = 1'b0;
        v3    = 1'b0;
        v4    = 1'b0;
        a3    = '0;
        b3    = '0;
        a4    = '0;
        b4    = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_identity();
        test_extremes();
        test_bubbles();
        test_clr();
        test_reset_mid_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
